comb_ocr_param: RTL and testbench
=================================

COMB_OCR_PARAM -- requirements
Module: comb_ocr_param

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter IMG_W, 16: image width in pixels (4..64).
REQ-002 The block SHALL have parameter IMG_H, 16: image height in pixels (4..64).
REQ-003 The block SHALL have parameter NCOMB, 3: comb lines per direction (1..8).
REQ-004 The block SHALL have parameter CODE_W, 4: OCR code width.
REQ-005 The block SHALL have parameter NCLASS, 10: template count, at most 2^CODE_W-1.
REQ-006 The block SHALL have parameter TEMPLATES, all zeros: NCLASS*FW bits, with template t at TEMPLATES[t*FW +: FW] and FW=4*NCOMB.
Ports (name, direction, width, meaning):
REQ-007 The block SHALL have CLK, input, 1: the single clock, rising edge.
REQ-008 The block SHALL have CLR, input, 1: asynchronous active-high reset.
REQ-009 The block SHALL have start, input, 1: begin recognition, sampled only in IDLE.
REQ-010 The block SHALL have pix_addr, output, clog2(IMG_W*IMG_H): pixel address = row*IMG_W+col.
REQ-011 The block SHALL have pix_data, input, 1: pixel (1=ink), valid one cycle after pix_addr.
REQ-012 The block SHALL have busy, output, 1: high from the cycle after start acceptance until done.
REQ-013 The block SHALL have done, output, 1: one-cycle completion pulse.
REQ-014 The block SHALL have feat, output, FW: the feature vector.
REQ-015 The block SHALL have OCR, output, CODE_W: the recognised class code.

Function
REQ-016 The FSM SHALL have states IDLE, HSCAN, VSCAN, DRAIN, CLASSIFY, DONE; transitions: IDLE->HSCAN on start; HSCAN->VSCAN after NCOMB*IMG_W addresses; VSCAN->DRAIN after NCOMB*IMG_H addresses; DRAIN->CLASSIFY->DONE->IDLE, one cycle each.
REQ-017 Comb row k SHALL be ((k+1)*IMG_H)/(NCOMB+1) and comb column k SHALL be ((k+1)*IMG_W)/(NCOMB+1), integer division, k=0..NCOMB-1.
REQ-018 HSCAN SHALL issue one address per cycle, columns 0..IMG_W-1 of comb row 0, then comb row 1, and so on; VSCAN SHALL issue rows 0..IMG_H-1 of comb column 0, then comb column 1, and so on.
REQ-019 Each comb line count SHALL be the number of 0->1 transitions along the line, with the pixel before position 0 taken as 0, saturating at 3 (2 bits).
REQ-020 Horizontal comb k SHALL map to feat[2k+1:2k] and vertical comb k to feat[2(NCOMB+k)+1:2(NCOMB+k)].
REQ-021 Counters and the previous-pixel register SHALL clear at each line start, and a line's last pixel SHALL be consumed before the next line's first pixel is counted.
REQ-022 In CLASSIFY, OCR SHALL register the lowest t whose template equals feat exactly, else the all-ones code.
REQ-023 done SHALL be high for exactly one cycle (DONE state), N+3 cycles after the start-accepting edge, where N=NCOMB*(IMG_W+IMG_H).
REQ-024 feat and OCR SHALL hold from done until the CLASSIFY of the next run; feat SHALL be cleared to 0 at the start of each run.
REQ-025 start SHALL be ignored outside IDLE, and start held high SHALL begin a new run on the first IDLE cycle after DONE.
REQ-026 pix_addr SHALL be 0 outside HSCAN/VSCAN.

Reset
REQ-027 CLR high SHALL immediately force IDLE with busy=0, done=0, feat=0, OCR=0 and pix_addr=0, and internal counters cleared, including mid-scan.
REQ-028 After CLR deasserts, the block SHALL require a fresh start; no partial result SHALL ever appear on done.

Verification
REQ-029 Defaults, all-zero image, start pulse -> done exactly 99 cycles after the start edge (N=96), feat=12'h000, OCR=0.
REQ-030 Image with ink only in column 7 -> each horizontal comb counts 1 and vertical combs (cols 4, 8, 12) count 0, giving feat=12'h015; with no matching template, OCR=4'hF.
REQ-031 Row 8 alternating 1,0,1,0... -> horizontal comb 1 saturates at 3, giving feat[3:2]=2'b11.
REQ-032 TEMPLATES with templates 2 and 5 both equal to the feature vector -> OCR=2 (lowest index wins).
REQ-033 CLR asserted for one cycle during VSCAN -> all outputs 0 the same cycle, no done pulse, and a following start gives the correct full result.
REQ-034 start held high continuously -> back-to-back runs with done every N+4 cycles, and start pulses while busy have no effect.

Source files
------------

// File: rtl/comb_ocr_param.sv
// Comb-line OCR: scans NCOMB horizontal and NCOMB vertical lines of a binary
// image, counts 0->1 transitions per line (saturating at 3) and matches the
// resulting feature vector against a set of fixed templates.
module comb_ocr_param #(
    parameter int unsigned IMG_W  = 16,
    parameter int unsigned IMG_H  = 16,
    parameter int unsigned NCOMB  = 3,
    parameter int unsigned CODE_W = 4,
    parameter int unsigned NCLASS = 10,
    parameter logic [NCLASS*4*NCOMB-1:0] TEMPLATES = '0
) (
    input  logic                                CLK,
    input  logic                                CLR,
    input  logic                                start,
    output logic [$clog2(IMG_W*IMG_H)-1:0]      pix_addr,
    input  logic                                pix_data,
    output logic                                busy,
    output logic                                done,
    output logic [4*NCOMB-1:0]                  feat,
    output logic [CODE_W-1:0]                   OCR
);

    localparam int unsigned FW   = 4 * NCOMB;
    localparam int unsigned AW   = $clog2(IMG_W * IMG_H);
    localparam int unsigned MAXD = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int unsigned PW   = $clog2(MAXD);
    localparam int unsigned LW   = (NCOMB > 1) ? $clog2(NCOMB) : 1;
    localparam int unsigned SW   = $clog2(2 * NCOMB);

    // Start address of each horizontal comb line (comb row * IMG_W)
    function automatic logic [NCOMB*AW-1:0] f_hbase();
        logic [NCOMB*AW-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < NCOMB; k++)
            r[k*AW +: AW] = AW'((((k + 1) * IMG_H) / (NCOMB + 1)) * IMG_W);
        return r;
    endfunction

    // Start address of each vertical comb line (comb column in row 0)
    function automatic logic [NCOMB*AW-1:0] f_vbase();
        logic [NCOMB*AW-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < NCOMB; k++)
            r[k*AW +: AW] = AW'(((k + 1) * IMG_W) / (NCOMB + 1));
        return r;
    endfunction

    localparam logic [NCOMB*AW-1:0] HBASE = f_hbase();
    localparam logic [NCOMB*AW-1:0] VBASE = f_vbase();

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HSCAN    = 3'd1,
        VSCAN    = 3'd2,
        DRAIN    = 3'd3,
        CLASSIFY = 3'd4,
        DONE     = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic [LW-1:0]       line_q, line_d, nxt_line;
    logic [AW-1:0]       addr_q, addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                vld_q, vld_d;
    logic                first_q, first_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic                prev_q, prev_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [FW-1:0]       acc_q, acc_d;
    logic [FW-1:0]       feat_q, feat_d;
    logic [CODE_W-1:0]   ocr_q, ocr_d;
    logic                rise;
    logic [1:0]          cnt_base;

    // Next-state, address generation, transition counting and classification
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        line_d   = line_q;
        addr_d   = '0;
        vld_d    = 1'b0;
        first_d  = 1'b0;
        slot_d   = '0;
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        feat_d   = feat_q;
        ocr_d    = ocr_q;
        nxt_line = line_q + LW'(1);
        rise     = 1'b0;
        cnt_base = 2'd0;

        // Pixel for the address issued last cycle; line-start resets history
        if (vld_q) begin
            rise     = pix_data & ~(prev_q & ~first_q);
            cnt_base = first_q ? 2'd0 : cnt_q;
            cnt_d    = (cnt_base == 2'd3) ? 2'd3 : cnt_base + {1'b0, rise};
            prev_d   = pix_data;
            acc_d[int'(slot_q)*2 +: 2] = cnt_d;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HSCAN;
                    pos_d   = '0;
                    line_d  = '0;
                    addr_d  = HBASE[0 +: AW];
                    acc_d   = '0;
                end
            end
            HSCAN: begin
                vld_d   = 1'b1;
                first_d = (pos_q == '0);
                slot_d  = SW'(line_q);
                if (pos_q == PW'(IMG_W - 1)) begin
                    pos_d = '0;
                    if (line_q == LW'(NCOMB - 1)) begin
                        state_d = VSCAN;
                        line_d  = '0;
                        addr_d  = VBASE[0 +: AW];
                    end else begin
                        line_d = nxt_line;
                        addr_d = HBASE[int'(nxt_line)*AW +: AW];
                    end
                end else begin
                    pos_d  = pos_q + PW'(1);
                    addr_d = addr_q + AW'(1);
                end
            end
            VSCAN: begin
                vld_d   = 1'b1;
                first_d = (pos_q == '0);
                slot_d  = SW'(NCOMB) + SW'(line_q);
                if (pos_q == PW'(IMG_H - 1)) begin
                    pos_d = '0;
                    if (line_q == LW'(NCOMB - 1)) begin
                        state_d = DRAIN;
                        line_d  = '0;
                    end else begin
                        line_d = nxt_line;
                        addr_d = VBASE[int'(nxt_line)*AW +: AW];
                    end
                end else begin
                    pos_d  = pos_q + PW'(1);
                    addr_d = addr_q + AW'(IMG_W);
                end
            end
            DRAIN: begin
                state_d = CLASSIFY;
            end
            CLASSIFY: begin
                state_d = DONE;
                feat_d  = acc_q;
                ocr_d   = '1;
                for (int t = int'(NCLASS) - 1; t >= 0; t--) begin
                    if (TEMPLATES[t*FW +: FW] == acc_q)
                        ocr_d = CODE_W'(t);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == HSCAN) || (state_d == VSCAN) ||
                 (state_d == DRAIN) || (state_d == CLASSIFY);
        done_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            pos_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            slot_q  <= '0;
            prev_q  <= 1'b0;
            cnt_q   <= 2'd0;
            acc_q   <= '0;
            feat_q  <= '0;
            ocr_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            first_q <= first_d;
            slot_q  <= slot_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            feat_q  <= feat_d;
            ocr_q   <= ocr_d;
        end
    end

    assign pix_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign feat     = feat_q;
    assign OCR      = ocr_q;

endmodule

// File: tb/tb_comb_ocr_param.sv
// Bench for comb_ocr_param: directed and random images checked against a
// behavioural model of the comb features and template match.
module tb_comb_ocr_param;

    localparam int W  = 16;
    localparam int H  = 16;
    localparam int NC = 3;
    localparam int N  = NC * (W + H);
    localparam logic [119:0] TPL = {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h544,
                                    12'hFFF, 12'hFFF, 12'h544, 12'hFFF, 12'h000};

    logic        CLK = 1'b0;
    logic        CLR;
    logic        start;
    logic [7:0]  pix_addr;
    logic        pix_data;
    logic        busy;
    logic        done;
    logic [11:0] feat;
    logic [3:0]  OCR;

    bit img [256];
    int checks = 0;
    int errors = 0;

    comb_ocr_param #(
        .IMG_W(16), .IMG_H(16), .NCOMB(3), .CODE_W(4), .NCLASS(10), .TEMPLATES(TPL)
    ) dut (
        .CLK(CLK), .CLR(CLR), .start(start), .pix_addr(pix_addr),
        .pix_data(pix_data), .busy(busy), .done(done), .feat(feat), .OCR(OCR)
    );

    always #5 CLK = ~CLK;

    // Image memory: data for an address is presented one cycle later
    always @(posedge CLK) pix_data <= img[pix_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transition count of every comb line, straight from the image
    function automatic logic [11:0] model_feat();
        logic [11:0] f;
        int r, c, cnt;
        bit prev;
        f = '0;
        for (int k = 0; k < NC; k++) begin
            r = ((k + 1) * H) / (NC + 1);
            cnt = 0; prev = 0;
            for (int x = 0; x < W; x++) begin
                if (img[r*W + x] && !prev) cnt++;
                prev = img[r*W + x];
            end
            f[2*k +: 2] = 2'((cnt > 3) ? 3 : cnt);
            c = ((k + 1) * W) / (NC + 1);
            cnt = 0; prev = 0;
            for (int y = 0; y < H; y++) begin
                if (img[y*W + c] && !prev) cnt++;
                prev = img[y*W + c];
            end
            f[2*(NC + k) +: 2] = 2'((cnt > 3) ? 3 : cnt);
        end
        return f;
    endfunction

    function automatic logic [3:0] model_ocr(input logic [11:0] f);
        for (int t = 0; t < 10; t++)
            if (TPL[t*12 +: 12] == f) return 4'(t);
        return 4'hF;
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 1'b0;
    endtask

    task automatic rand_img(input int density);
        for (int i = 0; i < 256; i++) img[i] = ($urandom_range(0, 99) < density);
    endtask

    // One run from IDLE; optional start pulse while busy at cycle pulse_at
    task automatic run(input string tag, input int pulse_at, output logic [11:0] f_out,
                       output logic [3:0] o_out);
        logic [11:0] ef;
        int k;
        bit got;
        ef = model_feat();
        @(negedge CLK); start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        k = 0; got = 0;
        while (k < 300 && !got) begin
            @(negedge CLK);
            k++;
            start = (k == pulse_at);
            if (k == 1) begin
                check({tag, " busy_after_start"}, 32'(busy), 32'd1);
                check({tag, " first_addr"}, 32'(pix_addr), 32'd64);
            end
            if (done) got = 1;
        end
        start = 1'b0;
        check({tag, " done_latency"}, 32'(k), 32'(N + 3));
        check({tag, " feat"}, 32'(feat), 32'(ef));
        check({tag, " ocr"}, 32'(OCR), 32'(model_ocr(ef)));
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check({tag, " addr_at_done"}, 32'(pix_addr), 32'd0);
        f_out = feat;
        o_out = OCR;
        @(negedge CLK);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        @(negedge CLK);
        check({tag, " idle_after"}, 32'(busy), 32'd0);
        check({tag, " hold_feat"}, 32'(feat), 32'(ef));
    endtask

    initial begin
        logic [11:0] f;
        logic [3:0]  o;
        int dt [3];
        int nd, k, ndone;

        CLR = 1'b1; start = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset feat", 32'(feat), 32'd0);
        check("reset ocr", 32'(OCR), 32'd0);
        check("reset addr", 32'(pix_addr), 32'd0);
        CLR = 1'b0;
        @(negedge CLK);

        // All-zero image matches template 0
        clear_img();
        run("zero", -1, f, o);
        check("zero feat_lit", 32'(f), 32'h000);
        check("zero ocr_lit", 32'(o), 32'h0);

        // Ink only in column 7
        clear_img();
        for (int r = 0; r < H; r++) img[r*W + 7] = 1'b1;
        run("col7", -1, f, o);
        check("col7 feat_lit", 32'(f), 32'h015);
        check("col7 ocr_lit", 32'(o), 32'hF);

        // Row 8 alternating saturates horizontal comb 1
        clear_img();
        for (int c = 0; c < W; c++) img[8*W + c] = (c % 2 == 0);
        run("alt", -1, f, o);
        check("alt sat", 32'(f[3:2]), 32'd3);

        // Row 8 solid matches templates 2 and 5; start pulse while busy ignored
        clear_img();
        for (int c = 0; c < W; c++) img[8*W + c] = 1'b1;
        run("row8", 20, f, o);
        check("row8 feat_lit", 32'(f), 32'h544);
        check("row8 ocr_lowest", 32'(o), 32'd2);

        for (int i = 0; i < 6; i++) begin
            rand_img(10 + 15 * i);
            run($sformatf("rand%0d", i), -1, f, o);
        end

        // Reset during the vertical scan
        rand_img(40);
        @(negedge CLK); start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        repeat (60) @(negedge CLK);
        CLR = 1'b1;
        #1;
        check("clr busy", 32'(busy), 32'd0);
        check("clr done", 32'(done), 32'd0);
        check("clr feat", 32'(feat), 32'd0);
        check("clr ocr", 32'(OCR), 32'd0);
        check("clr addr", 32'(pix_addr), 32'd0);
        @(negedge CLK); CLR = 1'b0;
        ndone = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge CLK);
            if (done || busy) ndone++;
        end
        check("clr no_restart", 32'(ndone), 32'd0);
        run("after_clr", -1, f, o);

        // start held high: back-to-back runs
        rand_img(35);
        @(negedge CLK); start = 1'b1;
        @(posedge CLK);
        k = 0; nd = 0;
        while (k < 400 && nd < 3) begin
            @(negedge CLK);
            k++;
            if (done) begin
                dt[nd] = k;
                check($sformatf("held feat%0d", nd), 32'(feat), 32'(model_feat()));
                nd++;
                if (nd == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("held count", 32'(nd), 32'd3);
        check("held first", 32'(dt[0]), 32'(N + 3));
        check("held period1", 32'(dt[1] - dt[0]), 32'(N + 4));
        check("held period2", 32'(dt[2] - dt[1]), 32'(N + 4));
        repeat (3) @(negedge CLK);
        check("held stop", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
